// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types and defaults for the memory port arbiter
package mem_port_arbiter_pkg;

  localparam int unsigned DEF_MEM_BYTES  = 8192;
  localparam int unsigned DEF_TIMEOUT    = 15;
  localparam int unsigned DEF_STARVE_MAX = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    FETCH  = 1'b0,
    MEMSTG = 1'b1
  } req_id_e;

  // A word access must fit entirely inside the memory.
  function automatic logic addr_legal(input logic [63:0] addr, input logic [63:0] mem_bytes);
    return addr <= (mem_bytes - 64'd8);
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and shared-memory signals of the arbiter
interface mem_port_arbiter_if;

  logic        f_req;
  logic [63:0] f_addr;
  logic        f_valid;
  logic [63:0] f_rdata;
  logic        f_error;

  logic        m_req;
  logic        m_we;
  logic [63:0] m_addr;
  logic [63:0] m_wdata;
  logic        m_valid;
  logic [63:0] m_rdata;
  logic        m_error;

  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_rdy;
  logic [63:0] mem_rdata;

  logic        busy;

  // Arbiter side.
  modport slave (
    input  f_req, f_addr,
    output f_valid, f_rdata, f_error,
    input  m_req, m_we, m_addr, m_wdata,
    output m_valid, m_rdata, m_error,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdy, mem_rdata,
    output busy
  );

  // Requester / memory side.
  modport master (
    output f_req, f_addr,
    input  f_valid, f_rdata, f_error,
    output m_req, m_we, m_addr, m_wdata,
    input  m_valid, m_rdata, m_error,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdy, mem_rdata,
    input  busy
  );

endinterface

// File: rtl/arb_timeout_ctr.sv
// rtl/arb_timeout_ctr.sv - loadable up-counter with terminal-count flag
module arb_timeout_ctr #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned TERMINAL = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  assign tc = (cnt_q == WIDTH'(TERMINAL));

  // Load wins over counting; the count holds once it reaches the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && !tc) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch / memory-stage arbiter for a single-port memory
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MEM_BYTES  = DEF_MEM_BYTES,
  parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
  parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
  input logic                 clk,
  input logic                 rst,
  mem_port_arbiter_if.slave   bus
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
  localparam logic [63:0]   MEM_BYTES_64 = 64'(MEM_BYTES);
  localparam logic [SW-1:0] STARVE_LIM   = SW'(STARVE_MAX);

  arb_state_e    state_q, state_d;
  req_id_e       id_q, id_d;
  logic          we_q, we_d;
  logic [63:0]   addr_q, addr_d;
  logic [63:0]   wdata_q, wdata_d;
  logic [63:0]   rdata_q, rdata_d;
  logic          err_q, err_d;
  logic [SW-1:0] starve_q, starve_d;

  logic          grant_mem;
  logic          tmr_load;
  logic          tmr_en;
  logic          tmr_tc;
  logic          in_busy;
  logic          in_resp;

  arb_timeout_ctr #(
    .WIDTH    (TW),
    .TERMINAL (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (TW'(1)),
    .en       (tmr_en),
    .tc       (tmr_tc)
  );

  // Arbitration, command latch and transaction sequencing.
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    starve_d  = starve_q;
    grant_mem = 1'b0;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.f_req) begin
          starve_d = '0;
        end
        if (bus.f_req || bus.m_req) begin
          grant_mem = bus.m_req && !(bus.f_req && (starve_q == STARVE_LIM));
          if (grant_mem) begin
            id_d    = MEMSTG;
            we_d    = bus.m_we;
            addr_d  = bus.m_addr;
            wdata_d = bus.m_wdata;
            // Memory stage can only beat a waiting fetch below the limit, so this never overflows.
            if (bus.f_req) begin
              starve_d = starve_q + SW'(1);
            end
          end else begin
            id_d     = FETCH;
            we_d     = 1'b0;
            addr_d   = bus.f_addr;
            wdata_d  = '0;
            starve_d = '0;
          end
          rdata_d = '0;
          if (addr_legal(addr_d, MEM_BYTES_64)) begin
            err_d    = 1'b0;
            tmr_load = 1'b1;
            state_d  = BUSY;
          end else begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      BUSY: begin
        tmr_en = 1'b1;
        if (bus.mem_rdy) begin
          rdata_d = bus.mem_rdata;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (tmr_tc) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and transaction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      id_q     <= FETCH;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      id_q     <= id_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      starve_q <= starve_d;
    end
  end

  assign in_busy = (state_q == BUSY);
  assign in_resp = (state_q == RESP);

  assign bus.busy      = (state_q != IDLE);
  assign bus.mem_req   = in_busy;
  assign bus.mem_we    = in_busy && we_q;
  assign bus.mem_addr  = in_busy ? addr_q  : '0;
  assign bus.mem_wdata = in_busy ? wdata_q : '0;

  assign bus.f_valid = in_resp && (id_q == FETCH);
  assign bus.f_rdata = bus.f_valid ? rdata_q : '0;
  assign bus.f_error = bus.f_valid && err_q;

  assign bus.m_valid = in_resp && (id_q == MEMSTG);
  assign bus.m_rdata = bus.m_valid ? rdata_q : '0;
  assign bus.m_error = bus.m_valid && err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam logic [63:0] MB = 64'(DEF_MEM_BYTES);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  mem_port_arbiter_if bus();

  mem_port_arbiter #(
    .MEM_BYTES  (DEF_MEM_BYTES),
    .TIMEOUT    (DEF_TIMEOUT),
    .STARVE_MAX (DEF_STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        is_m;
    logic [63:0] rdata;
    logic        err;
    int          cyc;
  } resp_t;

  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } cmd_t;

  resp_t sb_q[$];
  cmd_t  cmd_q[$];
  resp_t er;
  cmd_t  ec;

  int          n_tests   = 0;
  int          n_fail    = 0;
  int          rdy_at    = 1;
  int          bc        = 0;
  int          n0        = 0;
  logic [63:0] mem_val   = '0;
  logic        stray_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_resp(input logic is_m, input logic [63:0] rdata, input logic err, input int c);
    sb_q.push_back('{is_m, rdata, err, c});
  endtask

  task automatic exp_cmd(input logic we, input logic [63:0] addr, input logic [63:0] wdata);
    cmd_q.push_back('{we, addr, wdata});
  endtask

  task automatic port_m(input logic we, input logic [63:0] addr, input logic [63:0] wdata, input int n);
    int t;
    bus.m_req   = 1'b1;
    bus.m_we    = we;
    bus.m_addr  = addr;
    bus.m_wdata = wdata;
    for (int k = 0; k < n; k++) begin
      t = 0;
      @(negedge clk);
      while (!bus.m_valid && t < 60) begin
        @(negedge clk);
        t++;
      end
      if (!bus.m_valid) check("m_wait", 64'(bus.m_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    bus.m_req   = 1'b0;
    bus.m_we    = 1'b0;
    bus.m_addr  = '0;
    bus.m_wdata = '0;
  endtask

  task automatic port_f(input logic [63:0] addr, input int n);
    int t;
    bus.f_req  = 1'b1;
    bus.f_addr = addr;
    for (int k = 0; k < n; k++) begin
      t = 0;
      @(negedge clk);
      while (!bus.f_valid && t < 60) begin
        @(negedge clk);
        t++;
      end
      if (!bus.f_valid) check("f_wait", 64'(bus.f_valid), 64'd1);
    end
    @(posedge clk);
    #1;
    bus.f_req  = 1'b0;
    bus.f_addr = '0;
  endtask

  // Memory model: checks each new command and answers on busy cycle rdy_at (0 = never).
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.mem_req) begin
        bc = bc + 1;
        if (bc == 1) begin
          if (cmd_q.size() == 0) begin
            check("unexpected_mem_req", 64'(cmd_q.size()), 64'd1);
          end else begin
            ec = cmd_q.pop_front();
            check("mem_we", 64'(bus.mem_we), 64'(ec.we));
            check("mem_addr", bus.mem_addr, ec.addr);
            check("mem_wdata", bus.mem_wdata, ec.wdata);
          end
        end
        bus.mem_rdy   = (rdy_at != 0) && (bc == rdy_at);
        bus.mem_rdata = bus.mem_rdy ? mem_val : 64'hDEAD_BEEF_0BAD_F00D;
      end else begin
        bc            = 0;
        bus.mem_rdy   = stray_rdy;
        bus.mem_rdata = 64'h0BAD;
      end
    end
  end

  // Response monitor: every valid pulse must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && (bus.f_valid || bus.m_valid)) begin
        check("valid_overlap", 64'(bus.f_valid & bus.m_valid), 64'd0);
        if (sb_q.size() == 0) begin
          check("unexpected_resp", 64'(sb_q.size()), 64'd1);
        end else begin
          er = sb_q.pop_front();
          check("resp_port", 64'(bus.m_valid), 64'(er.is_m));
          check("resp_cycle", 64'(cyc), 64'(er.cyc));
          if (bus.m_valid) begin
            check("m_rdata", bus.m_rdata, er.rdata);
            check("m_error", 64'(bus.m_error), 64'(er.err));
            check("f_rdata_quiet", bus.f_rdata, 64'd0);
            check("f_error_quiet", 64'(bus.f_error), 64'd0);
          end else begin
            check("f_rdata", bus.f_rdata, er.rdata);
            check("f_error", 64'(bus.f_error), 64'(er.err));
            check("m_rdata_quiet", bus.m_rdata, 64'd0);
            check("m_error_quiet", 64'(bus.m_error), 64'd0);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bus.f_req     = 1'b0;
    bus.f_addr    = '0;
    bus.m_req     = 1'b0;
    bus.m_we      = 1'b0;
    bus.m_addr    = '0;
    bus.m_wdata   = '0;
    bus.mem_rdy   = 1'b0;
    bus.mem_rdata = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_mem_req", 64'(bus.mem_req), 64'd0);
    check("rst_mem_we", 64'(bus.mem_we), 64'd0);
    check("rst_mem_addr", bus.mem_addr, 64'd0);
    check("rst_f_valid", 64'(bus.f_valid), 64'd0);
    check("rst_m_valid", 64'(bus.m_valid), 64'd0);
    check("rst_m_rdata", bus.m_rdata, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Memory-stage write to address 8, ready on first busy cycle.
    rdy_at = 1; mem_val = 64'h77; n0 = cyc;
    exp_cmd(1'b1, 64'd8, 64'h55);
    exp_resp(1'b1, 64'h77, 1'b0, n0 + 2);
    port_m(1'b1, 64'd8, 64'h55, 1);
    repeat (2) @(posedge clk);
    #1;

    // Simultaneous requests: memory stage first, fetch after one idle cycle.
    rdy_at = 1; mem_val = 64'h1234; n0 = cyc;
    exp_cmd(1'b0, 64'h80, 64'd0);
    exp_cmd(1'b0, 64'h300, 64'd0);
    exp_resp(1'b1, 64'h1234, 1'b0, n0 + 2);
    exp_resp(1'b0, 64'h1234, 1'b0, n0 + 5);
    fork
      port_m(1'b0, 64'h80, 64'd0, 1);
      port_f(64'h300, 1);
    join
    repeat (2) @(posedge clk);
    #1;

    // Starvation: three memory-stage grants, then fetch, then memory stage again.
    rdy_at = 1; mem_val = 64'hABCD; n0 = cyc;
    for (int i = 0; i < 3; i++) exp_cmd(1'b0, 64'h100, 64'd0);
    exp_cmd(1'b0, 64'h200, 64'd0);
    exp_cmd(1'b0, 64'h100, 64'd0);
    exp_resp(1'b1, 64'hABCD, 1'b0, n0 + 2);
    exp_resp(1'b1, 64'hABCD, 1'b0, n0 + 5);
    exp_resp(1'b1, 64'hABCD, 1'b0, n0 + 8);
    exp_resp(1'b0, 64'hABCD, 1'b0, n0 + 11);
    exp_resp(1'b1, 64'hABCD, 1'b0, n0 + 14);
    fork
      port_m(1'b0, 64'h100, 64'd0, 4);
      port_f(64'h200, 1);
    join
    repeat (2) @(posedge clk);
    #1;

    // Illegal address just past the last word: no memory command, error response.
    n0 = cyc;
    exp_resp(1'b1, 64'd0, 1'b1, n0 + 1);
    port_m(1'b0, MB - 64'd7, 64'd0, 1);
    repeat (2) @(posedge clk);
    #1;

    // Last legal word address via fetch, ready on second busy cycle.
    rdy_at = 2; mem_val = 64'h42; n0 = cyc;
    exp_cmd(1'b0, MB - 64'd8, 64'd0);
    exp_resp(1'b0, 64'h42, 1'b0, n0 + 3);
    port_f(MB - 64'd8, 1);
    repeat (2) @(posedge clk);
    #1;

    // Timeout with no ready.
    rdy_at = 0; mem_val = 64'h66; n0 = cyc;
    exp_cmd(1'b0, 64'h18, 64'd0);
    exp_resp(1'b1, 64'd0, 1'b1, n0 + 16);
    port_m(1'b0, 64'h18, 64'd0, 1);
    repeat (2) @(posedge clk);
    #1;

    // Ready on the timeout cycle beats the timeout.
    rdy_at = 15; mem_val = 64'h99; n0 = cyc;
    exp_cmd(1'b0, 64'h18, 64'd0);
    exp_resp(1'b1, 64'h99, 1'b0, n0 + 16);
    port_m(1'b0, 64'h18, 64'd0, 1);
    repeat (2) @(posedge clk);
    #1;

    // Stray ready while idle must be ignored.
    stray_rdy = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("stray_busy", 64'(bus.busy), 64'd0);
    stray_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a busy transaction.
    rdy_at = 0;
    exp_cmd(1'b0, 64'h40, 64'd0);
    bus.m_req   = 1'b1;
    bus.m_we    = 1'b0;
    bus.m_addr  = 64'h40;
    bus.m_wdata = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_mem_req", 64'(bus.mem_req), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("rst_mid_mem_req", 64'(bus.mem_req), 64'd0);
    check("rst_mid_busy", 64'(bus.busy), 64'd0);
    check("rst_mid_m_valid", 64'(bus.m_valid), 64'd0);
    check("rst_mid_mem_addr", bus.mem_addr, 64'd0);
    @(posedge clk);
    #1;
    bus.m_req  = 1'b0;
    bus.m_addr = '0;
    rst        = 1'b0;
    @(posedge clk);
    #1;

    // Normal service after reset.
    rdy_at = 3; mem_val = 64'h5A; n0 = cyc;
    exp_cmd(1'b0, 64'h48, 64'd0);
    exp_resp(1'b1, 64'h5A, 1'b0, n0 + 4);
    port_m(1'b0, 64'h48, 64'd0, 1);
    repeat (3) @(posedge clk);
    #1;

    check("sb_drained", 64'(sb_q.size()), 64'd0);
    check("cmd_drained", 64'(cmd_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
